// File: rtl/data_mem_arbiter_pkg.sv
// rtl/data_mem_arbiter_pkg.sv - shared widths, port ids and range helper for the data memory arbiter
`ifndef DM_ARB_DEFINES
`define DM_ARB_DEFINES
`define DM_DATA_W 16
`define DM_ADDR_W 16
`endif

package data_mem_arbiter_pkg;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DMA = 1'b1
  } port_e;

  localparam int DATA_W                  = `DM_DATA_W;
  localparam int ADDR_W                  = `DM_ADDR_W;
  localparam int DEFAULT_MAX_CPU_BURST   = 4;
  localparam int DEFAULT_ADDR_DEPTH_BITS = 3;

  // Every bit above the backed depth must be zero.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr, input int depth_bits);
    return (addr >> depth_bits) == '0;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - one requester port of the data memory arbiter
interface data_mem_arbiter_if;
  import data_mem_arbiter_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/data_mem_arbiter_response.sv
// rtl/data_mem_arbiter_response.sv - per-port registered read response and error flag
module dm_arb_response
  import data_mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              granted,
  input  logic              we,
  input  logic              in_range,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      err    <= 1'b0;
    end else begin
      rvalid <= granted & ~we;
      err    <= granted & ~in_range;
      // rdata only moves on this port's own reads so it holds across the other port's traffic.
      if (granted && !we) begin
        rdata <= in_range ? mem_read_data : '0;
      end
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - CPU-priority arbiter for the 8x16 data memory with DMA starvation guard
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int MAX_CPU_BURST   = DEFAULT_MAX_CPU_BURST,
  parameter int ADDR_DEPTH_BITS = DEFAULT_ADDR_DEPTH_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  data_mem_arbiter_if.slave   p0,
  data_mem_arbiter_if.slave   p1,
  output logic [ADDR_W-1:0]   mem_access_addr,
  output logic [DATA_W-1:0]   mem_write_data,
  output logic                mem_write_en,
  output logic                mem_read,
  input  logic [DATA_W-1:0]   mem_read_data
);

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_CPU_BURST);

  logic [3:0]        starve_cnt;
  port_e             last_owner;
  logic              p0_win;
  logic              p1_win;
  logic              sel_we;
  logic              in_range;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Grants are held low while in reset so nothing reaches the memory pins.
  always_comb begin
    p0_win = 1'b0;
    p1_win = 1'b0;
    if (rst_n) begin
      if (p1.req && (starve_cnt == BURST_LIMIT || !p0.req)) begin
        p1_win = 1'b1;
      end else if (p0.req) begin
        p0_win = 1'b1;
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    if (p1_win) begin
      sel_addr  = p1.addr;
      sel_wdata = p1.wdata;
      sel_we    = p1.we;
    end else if (p0_win) begin
      sel_addr  = p0.addr;
      sel_wdata = p0.wdata;
      sel_we    = p0.we;
    end
  end

  assign in_range        = addr_in_range(sel_addr, ADDR_DEPTH_BITS);
  assign p0.gnt          = p0_win;
  assign p1.gnt          = p1_win;
  assign mem_access_addr = sel_addr;
  assign mem_write_data  = sel_wdata;
  assign mem_write_en    = (p0_win | p1_win) & sel_we & in_range;
  assign mem_read        = (p0_win | p1_win) & ~sel_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
      last_owner <= PORT_CPU;
    end else begin
      if (p1_win || !p1.req) begin
        starve_cnt <= 4'd0;
      end else if (p0_win && starve_cnt != BURST_LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
      if (p1_win) begin
        last_owner <= PORT_DMA;
      end else if (p0_win) begin
        last_owner <= PORT_CPU;
      end
    end
  end

  dm_arb_response u_resp_p0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .granted       (p0_win),
    .we            (p0.we),
    .in_range      (in_range),
    .mem_read_data (mem_read_data),
    .rvalid        (p0.rvalid),
    .rdata         (p0.rdata),
    .err           (p0.err)
  );

  dm_arb_response u_resp_p1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .granted       (p1_win),
    .we            (p1.we),
    .in_range      (in_range),
    .mem_read_data (mem_read_data),
    .rvalid        (p1.rvalid),
    .rdata         (p1.rdata),
    .err           (p1.err)
  );

  a_one_gnt: assert property (@(posedge clk) disable iff (!rst_n) !(p0_win && p1_win));
  a_p0_owner: assert property (@(posedge clk) disable iff (!rst_n) p0.rvalid |-> last_owner == PORT_CPU);
  a_p1_owner: assert property (@(posedge clk) disable iff (!rst_n) p1.rvalid |-> last_owner == PORT_DMA);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - directed self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [15:0] mem_access_addr;
  logic [15:0] mem_write_data;
  logic        mem_write_en;
  logic        mem_read;
  logic [15:0] mem_read_data;
  logic [15:0] mem [0:7];

  int total = 0;
  int bad   = 0;

  data_mem_arbiter_if p0_bus ();
  data_mem_arbiter_if p1_bus ();

  data_mem_arbiter #(
    .MAX_CPU_BURST   (4),
    .ADDR_DEPTH_BITS (3)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .p0              (p0_bus),
    .p1              (p1_bus),
    .mem_access_addr (mem_access_addr),
    .mem_write_data  (mem_write_data),
    .mem_write_en    (mem_write_en),
    .mem_read        (mem_read),
    .mem_read_data   (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write_en) mem[mem_access_addr[2:0]] <= mem_write_data;
  end
  assign mem_read_data = mem[mem_access_addr[2:0]];

  task automatic drive_p0(input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    p0_bus.req = req; p0_bus.we = we; p0_bus.addr = addr; p0_bus.wdata = wdata;
  endtask

  task automatic drive_p1(input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    p1_bus.req = req; p1_bus.we = we; p1_bus.addr = addr; p1_bus.wdata = wdata;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_p0(1'b1, 1'b1, 16'd3, 16'hBEEF);
    drive_p1(1'b1, 1'b0, 16'd7, 16'h0000);
    repeat (2) next_cycle();
    total++; if (mem_write_en !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%0b exp=0", mem_write_en); end
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL rst_mem_read got=%0b exp=0", mem_read); end
    total++; if ({p0_bus.gnt, p1_bus.gnt} !== 2'b00) begin bad++; $display("FAIL rst_gnt got=%b exp=00", {p0_bus.gnt, p1_bus.gnt}); end
    total++; if ({p0_bus.rvalid, p1_bus.rvalid, p0_bus.err, p1_bus.err} !== 4'b0000) begin bad++; $display("FAIL rst_flags got=%b exp=0000", {p0_bus.rvalid, p1_bus.rvalid, p0_bus.err, p1_bus.err}); end
    total++; if (p0_bus.rdata !== 16'h0000 || p1_bus.rdata !== 16'h0000) begin bad++; $display("FAIL rst_rdata got=%h/%h exp=0000/0000", p0_bus.rdata, p1_bus.rdata); end
    drive_p0(1'b0, 1'b0, 16'd0, 16'd0);
    drive_p1(1'b0, 1'b0, 16'd0, 16'd0);
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_write_read();
    drive_p0(1'b1, 1'b1, 16'd3, 16'hA5A5);
    #4;
    total++; if (p0_bus.gnt !== 1'b1) begin bad++; $display("FAIL wr_gnt got=%0b exp=1", p0_bus.gnt); end
    total++; if (mem_write_en !== 1'b1 || mem_access_addr !== 16'd3 || mem_write_data !== 16'hA5A5) begin bad++; $display("FAIL wr_mem got=%0b/%h/%h exp=1/0003/a5a5", mem_write_en, mem_access_addr, mem_write_data); end
    next_cycle();
    total++; if (p0_bus.rvalid !== 1'b0 || p0_bus.err !== 1'b0) begin bad++; $display("FAIL wr_resp got=%0b/%0b exp=0/0", p0_bus.rvalid, p0_bus.err); end
    drive_p0(1'b1, 1'b0, 16'd3, 16'h0000);
    #4;
    total++; if (p0_bus.gnt !== 1'b1 || mem_read !== 1'b1 || mem_write_en !== 1'b0) begin bad++; $display("FAIL rd_gnt got=%0b/%0b/%0b exp=1/1/0", p0_bus.gnt, mem_read, mem_write_en); end
    next_cycle();
    drive_p0(1'b0, 1'b0, 16'd0, 16'd0);
    total++; if (p0_bus.rvalid !== 1'b1 || p0_bus.rdata !== 16'hA5A5) begin bad++; $display("FAIL raw_rdata got=%0b/%h exp=1/a5a5", p0_bus.rvalid, p0_bus.rdata); end
    next_cycle();
    total++; if (p0_bus.rvalid !== 1'b0) begin bad++; $display("FAIL rvalid_pulse got=%0b exp=0", p0_bus.rvalid); end
  endtask

  task automatic test_dma_alone();
    drive_p1(1'b1, 1'b1, 16'd7, 16'h0F0F);
    #4;
    total++; if (p1_bus.gnt !== 1'b1 || p0_bus.gnt !== 1'b0) begin bad++; $display("FAIL dma_wr_gnt got=%0b%0b exp=10", p1_bus.gnt, p0_bus.gnt); end
    total++; if (mem_write_en !== 1'b1 || mem_access_addr !== 16'd7) begin bad++; $display("FAIL dma_wr_mem got=%0b/%h exp=1/0007", mem_write_en, mem_access_addr); end
    next_cycle();
    drive_p1(1'b1, 1'b0, 16'd7, 16'h0000);
    #4;
    total++; if (p1_bus.gnt !== 1'b1 || mem_read !== 1'b1) begin bad++; $display("FAIL dma_rd_gnt got=%0b/%0b exp=1/1", p1_bus.gnt, mem_read); end
    next_cycle();
    drive_p1(1'b0, 1'b0, 16'd0, 16'd0);
    total++; if (p1_bus.rvalid !== 1'b1 || p1_bus.rdata !== 16'h0F0F || p1_bus.err !== 1'b0) begin bad++; $display("FAIL dma_rdata got=%0b/%h/%0b exp=1/0f0f/0", p1_bus.rvalid, p1_bus.rdata, p1_bus.err); end
    total++; if (p0_bus.gnt !== 1'b0 || p0_bus.rvalid !== 1'b0 || p0_bus.err !== 1'b0) begin bad++; $display("FAIL dma_p0_quiet got=%0b/%0b/%0b exp=0/0/0", p0_bus.gnt, p0_bus.rvalid, p0_bus.err); end
    total++; if (p0_bus.rdata !== 16'hA5A5) begin bad++; $display("FAIL p0_rdata_hold got=%h exp=a5a5", p0_bus.rdata); end
    next_cycle();
  endtask

  task automatic test_out_of_range();
    drive_p0(1'b1, 1'b1, 16'd0, 16'h1234);
    #4;
    total++; if (mem_write_en !== 1'b1) begin bad++; $display("FAIL oor_pre_we got=%0b exp=1", mem_write_en); end
    next_cycle();
    drive_p0(1'b1, 1'b1, 16'h0008, 16'hFFFF);
    #4;
    total++; if (p0_bus.gnt !== 1'b1 || mem_write_en !== 1'b0) begin bad++; $display("FAIL oor_wr_we got=%0b/%0b exp=1/0", p0_bus.gnt, mem_write_en); end
    next_cycle();
    total++; if (p0_bus.err !== 1'b1 || p0_bus.rvalid !== 1'b0) begin bad++; $display("FAIL oor_wr_err got=%0b/%0b exp=1/0", p0_bus.err, p0_bus.rvalid); end
    drive_p0(1'b1, 1'b0, 16'd0, 16'h0000);
    #4;
    total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL oor_rd0_read got=%0b exp=1", mem_read); end
    next_cycle();
    total++; if (p0_bus.rvalid !== 1'b1 || p0_bus.rdata !== 16'h1234 || p0_bus.err !== 1'b0) begin bad++; $display("FAIL oor_rd0_data got=%0b/%h/%0b exp=1/1234/0", p0_bus.rvalid, p0_bus.rdata, p0_bus.err); end
    drive_p0(1'b1, 1'b0, 16'h0008, 16'h0000);
    #4;
    total++; if (p0_bus.gnt !== 1'b1 || mem_read !== 1'b1) begin bad++; $display("FAIL oor_rd8_gnt got=%0b/%0b exp=1/1", p0_bus.gnt, mem_read); end
    next_cycle();
    drive_p0(1'b0, 1'b0, 16'd0, 16'd0);
    total++; if (p0_bus.rvalid !== 1'b1 || p0_bus.rdata !== 16'h0000 || p0_bus.err !== 1'b1) begin bad++; $display("FAIL oor_rd8_data got=%0b/%h/%0b exp=1/0000/1", p0_bus.rvalid, p0_bus.rdata, p0_bus.err); end
    next_cycle();
    total++; if (p0_bus.err !== 1'b0) begin bad++; $display("FAIL oor_err_pulse got=%0b exp=0", p0_bus.err); end
  endtask

  task automatic test_contention();
    logic [0:9] pat;
    pat = 10'b0000100001;
    drive_p0(1'b1, 1'b0, 16'd3, 16'h0000);
    drive_p1(1'b1, 1'b0, 16'd7, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      #4;
      total++; if (p0_bus.gnt !== ~pat[i] || p1_bus.gnt !== pat[i]) begin bad++; $display("FAIL cont_gnt[%0d] got=p0:%0b p1:%0b exp=p0:%0b p1:%0b", i, p0_bus.gnt, p1_bus.gnt, ~pat[i], pat[i]); end
      next_cycle();
      total++; if (p0_bus.rvalid !== ~pat[i] || p1_bus.rvalid !== pat[i]) begin bad++; $display("FAIL cont_rvalid[%0d] got=%0b%0b exp=%0b%0b", i, p0_bus.rvalid, p1_bus.rvalid, ~pat[i], pat[i]); end
      if (pat[i]) begin
        total++; if (p1_bus.rdata !== 16'h0F0F) begin bad++; $display("FAIL cont_p1_rdata[%0d] got=%h exp=0f0f", i, p1_bus.rdata); end
      end else begin
        total++; if (p0_bus.rdata !== 16'hA5A5) begin bad++; $display("FAIL cont_p0_rdata[%0d] got=%h exp=a5a5", i, p0_bus.rdata); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [0:4] pat;
    pat = 5'b00001;
    drive_p0(1'b1, 1'b0, 16'h0008, 16'h0000);
    drive_p1(1'b1, 1'b0, 16'd7, 16'h0000);
    repeat (2) next_cycle();
    total++; if (p0_bus.rvalid !== 1'b1 || p0_bus.err !== 1'b1 || dut.starve_cnt !== 4'd2) begin bad++; $display("FAIL mid_pre got=%0b/%0b/%0d exp=1/1/2", p0_bus.rvalid, p0_bus.err, dut.starve_cnt); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (p0_bus.rvalid !== 1'b0 || p0_bus.err !== 1'b0 || dut.starve_cnt !== 4'd0) begin bad++; $display("FAIL mid_async got=%0b/%0b/%0d exp=0/0/0", p0_bus.rvalid, p0_bus.err, dut.starve_cnt); end
    total++; if (p0_bus.gnt !== 1'b0 || p1_bus.gnt !== 1'b0 || mem_read !== 1'b0) begin bad++; $display("FAIL mid_mem_off got=%0b/%0b/%0b exp=0/0/0", p0_bus.gnt, p1_bus.gnt, mem_read); end
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #4;
      total++; if (p0_bus.gnt !== ~pat[i] || p1_bus.gnt !== pat[i]) begin bad++; $display("FAIL mid_gnt[%0d] got=p0:%0b p1:%0b exp=p0:%0b p1:%0b", i, p0_bus.gnt, p1_bus.gnt, ~pat[i], pat[i]); end
      next_cycle();
    end
    drive_p0(1'b0, 1'b0, 16'd0, 16'd0);
    drive_p1(1'b0, 1'b0, 16'd0, 16'd0);
  endtask

  task automatic test_idle();
    for (int i = 0; i < 5; i++) begin
      #4;
      total++; if (p0_bus.gnt !== 1'b0 || p1_bus.gnt !== 1'b0) begin bad++; $display("FAIL idle_gnt[%0d] got=%0b%0b exp=00", i, p0_bus.gnt, p1_bus.gnt); end
      total++; if (mem_write_en !== 1'b0 || mem_read !== 1'b0 || mem_access_addr !== 16'h0000) begin bad++; $display("FAIL idle_mem[%0d] got=%0b/%0b/%h exp=0/0/0000", i, mem_write_en, mem_read, mem_access_addr); end
      next_cycle();
      total++; if (p0_bus.rvalid !== 1'b0 || p1_bus.rvalid !== 1'b0) begin bad++; $display("FAIL idle_rvalid[%0d] got=%0b%0b exp=00", i, p0_bus.rvalid, p1_bus.rvalid); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_dma_alone();
    test_out_of_range();
    test_contention();
    test_reset_mid();
    test_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
